// File: rtl/ptc_pkg.sv
// Shared types and constants for the PTC delay-line tap stepper.
// The helpers here size the tap vector from the coarse select width.
package ptc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OVERLAP = 2'd1,
        SETTLE  = 2'd2
    } ptc_state_e;

    localparam int unsigned RESET_SEL = 32'd1;

    function automatic int unsigned ntap_of(input int unsigned sel_w);
        return (32'd1 << sel_w) - 32'd1;
    endfunction

endpackage

// File: rtl/ptc_sel_to_tap.sv
// Combinational select-to-tap encoder: select 0 is bypass (all zero),
// select k>0 lights bit k-1 (one-hot) or bits k-1..0 (thermometer).
module ptc_sel_to_tap
    import ptc_pkg::*;
#(
    parameter int unsigned SEL_W  = 4,
    parameter bit          THERMO = 1'b0
) (
    input  logic [SEL_W-1:0]            sel,
    output logic [ntap_of(SEL_W)-1:0]   vec
);

    localparam int unsigned NTAP = ntap_of(SEL_W);

    int unsigned sel_ext_s;
    assign sel_ext_s = 32'(sel);

    // Tap k (1-based) is lit when the select reaches it (thermometer) or equals it (one-hot).
    always_comb begin
        vec = '0;
        for (int unsigned k = 32'd1; k <= NTAP; k++) begin
            if (THERMO) begin
                vec[k-32'd1] = (sel_ext_s >= k);
            end else begin
                vec[k-32'd1] = (sel_ext_s == k);
            end
        end
    end

endmodule

// File: rtl/ptc_tap_stepper.sv
// Walks the delay-line tap select toward the latest coarse target one tap at a time,
// with a settle gap after every step and an optional make-before-break overlap.
module ptc_tap_stepper
    import ptc_pkg::*;
#(
    parameter int unsigned CODE_W     = 10,
    parameter int unsigned SEL_W      = 4,
    parameter int unsigned SETTLE_CYC = 3,
    parameter bit          THERMO     = 1'b0,
    parameter bit          MBB        = 1'b0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [CODE_W-1:0]           code,
    input  logic                        code_vld,
    input  logic                        hold,
    output logic [ntap_of(SEL_W)-1:0]   T,
    output logic [ntap_of(SEL_W)-1:0]   Tb,
    output logic [SEL_W-1:0]            cur_sel,
    output logic                        busy,
    output logic                        at_target
);

    localparam int unsigned       NTAP      = ntap_of(SEL_W);
    localparam bit                MBB_EFF   = MBB && !THERMO;
    localparam logic [7:0]        SETTLE_LD = 8'(SETTLE_CYC);
    localparam logic [SEL_W-1:0]  SEL_RST   = SEL_W'(RESET_SEL);
    localparam logic [NTAP-1:0]   T_RST     = {{(NTAP-1){1'b0}}, 1'b1};

    ptc_state_e        state_r,    state_nx_s;
    logic [SEL_W-1:0]  tgt_r,      tgt_nx_s;
    logic [SEL_W-1:0]  cur_sel_r,  cur_sel_nx_s;
    logic [SEL_W-1:0]  pend_sel_r, pend_sel_nx_s;
    logic [7:0]        cnt_r,      cnt_nx_s;
    logic [NTAP-1:0]   t_r,        t_nx_s;
    logic [NTAP-1:0]   tb_r;
    logic              busy_r,     busy_nx_s;
    logic              at_tgt_r,   at_tgt_nx_s;
    logic [SEL_W-1:0]  step_sel_s;
    logic [SEL_W-1:0]  new_sel_s;
    logic [NTAP-1:0]   old_vec_s;
    logic [NTAP-1:0]   new_vec_s;
    logic              code_unused_s;

    assign code_unused_s = ^code[CODE_W-SEL_W-1:0];

    // Neighbour select one tap toward the target; tgt is always in range so this never wraps.
    always_comb begin
        if (tgt_r > cur_sel_r) begin
            step_sel_s = cur_sel_r + SEL_W'(1);
        end else if (tgt_r < cur_sel_r) begin
            step_sel_s = cur_sel_r - SEL_W'(1);
        end else begin
            step_sel_s = cur_sel_r;
        end
    end

    // During OVERLAP the step direction was fixed on entry, so a retarget cannot redirect it.
    assign new_sel_s = (state_r == OVERLAP) ? pend_sel_r : step_sel_s;

    ptc_sel_to_tap #(.SEL_W(SEL_W), .THERMO(THERMO)) u_old_vec (
        .sel (cur_sel_r),
        .vec (old_vec_s)
    );

    ptc_sel_to_tap #(.SEL_W(SEL_W), .THERMO(THERMO)) u_new_vec (
        .sel (new_sel_s),
        .vec (new_vec_s)
    );

    // Next-state, next-select and next tap vector.
    always_comb begin
        state_nx_s    = state_r;
        cur_sel_nx_s  = cur_sel_r;
        pend_sel_nx_s = pend_sel_r;
        cnt_nx_s      = cnt_r;
        t_nx_s        = t_r;
        tgt_nx_s      = code_vld ? code[CODE_W-1 -: SEL_W] : tgt_r;
        case (state_r)
            IDLE: begin
                if (!hold && (tgt_r != cur_sel_r)) begin
                    if (MBB_EFF) begin
                        t_nx_s        = old_vec_s | new_vec_s;
                        pend_sel_nx_s = step_sel_s;
                        state_nx_s    = OVERLAP;
                    end else begin
                        cur_sel_nx_s = step_sel_s;
                        t_nx_s       = new_vec_s;
                        cnt_nx_s     = SETTLE_LD;
                        state_nx_s   = SETTLE;
                    end
                end else begin
                    state_nx_s = IDLE;
                end
            end
            OVERLAP: begin
                cur_sel_nx_s = pend_sel_r;
                t_nx_s       = new_vec_s;
                cnt_nx_s     = SETTLE_LD;
                state_nx_s   = SETTLE;
            end
            SETTLE: begin
                if (cnt_r <= 8'd1) begin
                    state_nx_s = IDLE;
                end else begin
                    cnt_nx_s = cnt_r - 8'd1;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
        busy_nx_s   = (state_nx_s != IDLE) || (tgt_nx_s != cur_sel_nx_s);
        at_tgt_nx_s = !busy_nx_s;
    end

    // State and output flops; status is computed from next values so it lines up with cur_sel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            tgt_r      <= SEL_RST;
            cur_sel_r  <= SEL_RST;
            pend_sel_r <= SEL_RST;
            cnt_r      <= 8'd0;
            t_r        <= T_RST;
            tb_r       <= ~T_RST;
            busy_r     <= 1'b0;
            at_tgt_r   <= 1'b1;
        end else begin
            state_r    <= state_nx_s;
            tgt_r      <= tgt_nx_s;
            cur_sel_r  <= cur_sel_nx_s;
            pend_sel_r <= pend_sel_nx_s;
            cnt_r      <= cnt_nx_s;
            t_r        <= t_nx_s;
            tb_r       <= ~t_nx_s;
            busy_r     <= busy_nx_s;
            at_tgt_r   <= at_tgt_nx_s;
        end
    end

    assign T         = t_r;
    assign Tb        = tb_r;
    assign cur_sel   = cur_sel_r;
    assign busy      = busy_r;
    assign at_target = at_tgt_r;

endmodule

// File: tb/tb_ptc_tap_stepper.sv
// Three stepper flavours (one-hot, thermometer, one-hot with overlap) share one stimulus
// stream and are compared every cycle against a step/cooldown model of the tap walk.
module tb_ptc_tap_stepper;

    localparam int S = 3;

    logic        clk;
    logic        rst_n;
    logic [9:0]  code;
    logic        code_vld;
    logic        hold;
    logic [14:0] t_w   [3];
    logic [14:0] tb_w  [3];
    logic [3:0]  sel_w [3];
    logic        busy_w[3];
    logic        at_w  [3];

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        ptc_tap_stepper #(
            .CODE_W(10), .SEL_W(4), .SETTLE_CYC(S),
            .THERMO(g == 1), .MBB(g == 2)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .code      (code),
            .code_vld  (code_vld),
            .hold      (hold),
            .T         (t_w[g]),
            .Tb        (tb_w[g]),
            .cur_sel   (sel_w[g]),
            .busy      (busy_w[g]),
            .at_target (at_w[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [14:0] vec(input int s, input bit th);
        vec = '0;
        if (th) begin
            for (int k = 0; k < s; k++) vec[k] = 1'b1;
        end else if (s > 0) begin
            vec[s-1] = 1'b1;
        end
    endfunction

    function automatic int toward(input int s, input int t);
        return (t > s) ? s + 1 : s - 1;
    endfunction

    // Model: a step may start only when no cooldown is pending; an overlap step commits one cycle later.
    int          m_sel[3], m_tgt[3], m_cool[3], m_pend[3];
    logic [14:0] m_t[3];
    int          n_sel[3], n_tgt[3], n_cool[3], n_pend[3];
    logic [14:0] n_t[3];

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            n_sel[i]  = m_sel[i];
            n_t[i]    = m_t[i];
            n_cool[i] = m_cool[i];
            n_pend[i] = m_pend[i];
            n_tgt[i]  = code_vld ? int'(code[9:6]) : m_tgt[i];
            if (m_pend[i] >= 0) begin
                n_sel[i]  = m_pend[i];
                n_t[i]    = vec(m_pend[i], i == 1);
                n_pend[i] = -1;
                n_cool[i] = S;
            end else if (m_cool[i] > 0) begin
                n_cool[i] = m_cool[i] - 1;
            end else if (!hold && m_tgt[i] != m_sel[i]) begin
                if (i == 2) begin
                    n_t[i]    = vec(m_sel[i], 1'b0) | vec(toward(m_sel[i], m_tgt[i]), 1'b0);
                    n_pend[i] = toward(m_sel[i], m_tgt[i]);
                end else begin
                    n_sel[i]  = toward(m_sel[i], m_tgt[i]);
                    n_t[i]    = vec(n_sel[i], i == 1);
                    n_cool[i] = S;
                end
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                m_sel[i] <= 1; m_tgt[i] <= 1; m_cool[i] <= 0; m_pend[i] <= -1; m_t[i] <= 15'h0001;
            end else begin
                m_sel[i] <= n_sel[i]; m_tgt[i] <= n_tgt[i]; m_cool[i] <= n_cool[i];
                m_pend[i] <= n_pend[i]; m_t[i] <= n_t[i];
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every instance against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("T[%0d]", i), {17'd0, t_w[i]}, {17'd0, m_t[i]});
                chk($sformatf("Tb[%0d]", i), {17'd0, tb_w[i]}, {17'd0, ~m_t[i]});
                chk($sformatf("cur_sel[%0d]", i), {28'd0, sel_w[i]}, m_sel[i]);
                chk($sformatf("busy[%0d]", i), {31'd0, busy_w[i]},
                    {31'd0, (m_cool[i] > 0) || (m_pend[i] >= 0) || (m_tgt[i] != m_sel[i])});
                chk($sformatf("at_target[%0d]", i), {31'd0, at_w[i]},
                    {31'd0, (m_cool[i] == 0) && (m_pend[i] < 0) && (m_tgt[i] == m_sel[i])});
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_code(input logic [9:0] c);
        code = c; code_vld = 1'b1;
        tick();
        code_vld = 1'b0;
    endtask

    initial begin
        bit found;
        rst_n = 1'b0; code = 10'd0; code_vld = 1'b0; hold = 1'b0;
        repeat (2) tick();
        rst_n  = 1'b1;
        chk_en = 1'b1;
        chk("rst_T", {17'd0, t_w[0]}, 32'h0001);
        chk("rst_Tb", {17'd0, tb_w[0]}, 32'h7FFE);
        chk("rst_sel", {28'd0, sel_w[0]}, 32'd1);
        chk("rst_at", {31'd0, at_w[0]}, 32'd1);
        chk("rst_T_thermo", {17'd0, t_w[1]}, 32'h0001);

        // Walk 1 -> 5: steps every 4 cycles, idle 3 cycles after the last step.
        pulse_code(10'h140);
        chk("capture_busy", {31'd0, busy_w[0]}, 32'd1);
        chk("capture_sel", {28'd0, sel_w[0]}, 32'd1);
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk($sformatf("walk_sel_%0d", i), {28'd0, sel_w[0]}, 1 + (i + 3) / 4);
            chk($sformatf("walk_at_%0d", i), {31'd0, at_w[0]}, {31'd0, i == 16});
            if (i == 1) chk("mbb_overlap_T", {17'd0, t_w[2]}, 32'h0003);
            if (i == 1) chk("mbb_overlap_sel", {28'd0, sel_w[2]}, 32'd1);
            if (i == 2) chk("mbb_commit_T", {17'd0, t_w[2]}, 32'h0002);
            if (i == 2) chk("mbb_commit_sel", {28'd0, sel_w[2]}, 32'd2);
        end
        chk("sel5_T", {17'd0, t_w[0]}, 32'h0010);
        chk("sel5_Tb", {17'd0, tb_w[0]}, 32'h7FEF);
        chk("thermo5_T", {17'd0, t_w[1]}, 32'h001F);
        repeat (5) tick();

        // Thermometer walk down to bypass.
        pulse_code(10'h000);
        repeat (30) tick();
        chk("thermo0_T", {17'd0, t_w[1]}, 32'h0000);
        chk("thermo0_Tb", {17'd0, tb_w[1]}, 32'h7FFF);
        chk("onehot0_sel", {28'd0, sel_w[0]}, 32'd0);

        // Toward 9, retarget to 3 at select 6 while holding for 10 cycles.
        pulse_code(10'h240);
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            tick();
            if (sel_w[0] == 4'd6) found = 1'b1;
        end
        chk("reach_sel6", {31'd0, found}, 32'd1);
        code = 10'h0C0; code_vld = 1'b1; hold = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            code_vld = 1'b0;
            chk($sformatf("hold_sel_%0d", k), {28'd0, sel_w[0]}, 32'd6);
            chk($sformatf("hold_busy_%0d", k), {31'd0, busy_w[0]}, 32'd1);
        end
        hold = 1'b0;
        tick();
        chk("rev_sel5", {28'd0, sel_w[0]}, 32'd5);
        repeat (4) tick();
        chk("rev_sel4", {28'd0, sel_w[0]}, 32'd4);
        repeat (4) tick();
        chk("rev_sel3", {28'd0, sel_w[0]}, 32'd3);
        repeat (10) tick();

        // Asynchronous reset in the middle of a settle interval.
        pulse_code(10'h100);
        tick();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("arst_T_%0d", i), {17'd0, t_w[i]}, 32'h0001);
            chk($sformatf("arst_Tb_%0d", i), {17'd0, tb_w[i]}, 32'h7FFE);
            chk($sformatf("arst_sel_%0d", i), {28'd0, sel_w[i]}, 32'd1);
            chk($sformatf("arst_busy_%0d", i), {31'd0, busy_w[i]}, 32'd0);
            chk($sformatf("arst_at_%0d", i), {31'd0, at_w[i]}, 32'd1);
        end
        tick();
        rst_n = 1'b1;
        repeat (20) tick();
        chk("post_rst_sel", {28'd0, sel_w[0]}, 32'd1);
        chk("post_rst_at", {31'd0, at_w[0]}, 32'd1);

        // Randomized targets and holds.
        for (int k = 0; k < 3000; k++) begin
            code     = 10'($urandom);
            code_vld = ($urandom_range(0, 15) == 0);
            hold     = ($urandom_range(0, 7) == 0);
            tick();
        end
        code_vld = 1'b0; hold = 1'b0;
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ptc_tap_stepper.md
# ptc_tap_stepper

Parametrised, registered successor to the PTC 4-to-16 tap decoder in the FMDLL delay-line control path. It takes the coarse field of the DLL control code and walks the delay-line tap select toward that target one tap at a time. A programmable settle interval separates steps, and an optional make-before-break overlap prevents phase glitches. Outputs drive the delay-line tap enables (true and complement) directly from flops.

## Interface
- CODE_W, 10, width of the incoming control code
- SEL_W, 4, coarse field width; taken from code[CODE_W-1 -: SEL_W]; NTAP = 2**SEL_W - 1 tap outputs
- SETTLE_CYC, 3, idle cycles after each step; legal range 1..255
- THERMO, 0, 0 = one-hot tap vector, 1 = thermometer tap vector
- MBB, 0, 1 = make-before-break overlap cycle on each step; one-hot mode only, ignored when THERMO=1

Ports:
- clk  in  1  single clock
- rst_n  in  1  asynchronous, active-low reset
- code  in  CODE_W  DLL control code
- code_vld  in  1  capture the target from code this cycle
- hold  in  1  block new steps; an in-flight step and settle still complete
- T  out  NTAP  tap enable vector
- Tb  out  NTAP  bitwise complement of T, registered in the same flop stage
- cur_sel  out  SEL_W  currently applied select
- busy  out  1  state != IDLE, or tgt != cur_sel
- at_target  out  1  state == IDLE and tgt == cur_sel

## Operation
- Select mapping:
  - Select 0: T all zero (bypass).
  - Select k>0, one-hot: only bit k-1 set.
  - Select k>0, thermometer: bits k-1..0 set.
- Target register tgt:
  - Loaded from code[CODE_W-1 -: SEL_W] on any cycle with code_vld=1, in any state.
  - A later code_vld overwrites an earlier one; only the latest target matters.
- FSM states are IDLE, OVERLAP and SETTLE.
- IDLE:
  - If hold=0 and tgt != cur_sel, then cur_sel <= cur_sel ± 1 toward tgt.
  - Normal step: T/Tb take the new select's vector; go to SETTLE and load the counter with SETTLE_CYC.
  - MBB one-hot step: T <= old vector | new vector, and cur_sel does not change yet; go to OVERLAP.
  - Otherwise stay in IDLE.
- OVERLAP: T <= new vector and cur_sel updates; go to SETTLE and load the counter.
- SETTLE: decrement the counter; at 1, go to IDLE.
- Steps are always ±1. cur_sel never wraps: stepping 0→NTAP and NTAP→0 is impossible.
- Retarget mid-walk: the walk continues from cur_sel toward the new tgt and may reverse direction.
- Reset (asynchronous):
  - state=IDLE, tgt=1, cur_sel=1.
  - One-hot: T=1, Tb=~1.
  - Thermometer: T=1, Tb=~1.
  - A reset asserted mid-walk abandons the walk immediately.

## Timing
- code_vld sampled at edge n → tgt valid after edge n. The first T change occurs at edge n+1 if in IDLE with hold=0.
- Step period is 1+SETTLE_CYC cycles, or 2+SETTLE_CYC with MBB overlap.
- A walk of d taps completes in d·(1+SETTLE_CYC) cycles without MBB.
- T, Tb, cur_sel, busy and at_target are all registered. There is no combinational path from inputs to outputs.
- hold sampled high in IDLE → no step that cycle. hold is ignored in OVERLAP and SETTLE.

## Structure
- ptc_pkg holds:
  - the state enum (IDLE, OVERLAP, SETTLE)
  - the reset select constant (1)
  - the select-width helper function
- One sub-module, ptc_sel_to_tap: a combinational select→vector encoder parametrised by SEL_W and THERMO.
  - Instantiated twice: for the old and the new vector, which are needed for the OVERLAP OR.

## Test plan
- Reset, defaults → T=15'h0001, Tb=15'h7FFE, cur_sel=1, at_target=1.
- code=10'h140 (sel 5) with code_vld for 1 cycle →
  - cur_sel steps 2,3,4,5 at 4-cycle spacing;
  - final T=15'h0010, Tb=15'h7FEF;
  - at_target rises 3 cycles after the last step.
- THERMO=1, target 5 → T=15'h001F. Then target 0 → T walks down to 15'h0000 and Tb=15'h7FFF.
- MBB=1, target 2 from reset →
  - T=15'h0003 for exactly 1 cycle, then 15'h0002;
  - the step takes 5 cycles in total.
- Walking toward 9, retarget to 3 when cur_sel=6 → the walk reverses to 5,4,3 with no skipped value. Throughout, hold=1 is applied in IDLE for 10 cycles → cur_sel is frozen, busy=1.
- rst_n pulsed low mid-step (during SETTLE) → all outputs return to their reset values asynchronously. The walk is abandoned: with tgt=1 after reset, no stepping resumes after release.
